regwb_arbiter: RTL and testbench
================================

Name: regwb_arbiter

Overview:
- Sole writer for the pipeline register file's single write port. It drives the register file's write-enable, write-address and write-data inputs.
- Merges two result sources:
  - the in-order MEM/WB pipeline result, which arrives every cycle and has absolute priority;
  - the long-latency mult/div unit result, which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a busy scoreboard of destination registers with mult/div results outstanding. It gives decode a combinational stall for reads of those registers.

Parameters:
- MD_DEPTH, 2, mult/div result FIFO depth (power of two, at least 2).
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers; register 0 hard-wired to zero).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_regWr  in  1  pipeline write request this cycle.
- wb_writeimport  in  ADDR_W  pipeline destination register.
- wb_Writedata  in  DATA_W  pipeline result.
- md_issue  in  1  mult/div op launched this cycle.
- md_issue_rd  in  ADDR_W  destination register of the launched op.
- md_valid  in  1  mult/div result offered.
- md_ready  out  1  arbiter accepts the offered result.
- md_rd  in  ADDR_W  destination register of the offered result.
- md_data  in  DATA_W  offered result.
- readimport1  in  ADDR_W  decode source register 1.
- readimport2  in  ADDR_W  decode source register 2.
- stall  out  1  a decode source register is busy.
- rf_regWr  out  1  write enable to the register file (registered).
- rf_writeimport  out  ADDR_W  write address to the register file (registered).
- rf_Writedata  out  DATA_W  write data to the register file (registered).
- md_count  out  $clog2(MD_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - rf_regWr, rf_writeimport, rf_Writedata, md_count all go to 0;
  - FIFO is emptied and its pointers zeroed;
  - busy[31:1] and the pending-clear register are zeroed;
  - md_ready reads 1 in the cycle after reset.
  - Reset mid-operation discards buffered results and outstanding busy bits.
- A valid pipeline write means wb_regWr=1 and wb_writeimport!=0. A pipeline write to register 0 is dropped and counts as idle.
- Arbitration, evaluated each cycle:
  - Valid pipeline write: at the edge, rf_* take the pipeline values with rf_regWr=1. The FIFO does not pop.
  - Otherwise, FIFO non-empty: pop the head; rf_* take the head entry with rf_regWr=1.
  - Otherwise: rf_regWr=0. rf_writeimport and rf_Writedata hold their previous values.
- Latency:
  - pipeline path: 1 edge to the rf_* outputs; the register file commits at the following edge.
  - mult/div path: result accepted at edge N. Earliest rf_* drive is at edge N+1, and only if the pipeline is idle in cycle N+1. The FIFO is never bypassed.
- Handshake:
  - md_ready = (md_count < MD_DEPTH); it is a function of registered count only and does not depend on a same-cycle pop.
  - Transfer occurs when md_valid=1 and md_ready=1; push at that edge.
  - Simultaneous push and pop when not full: count is unchanged.
  - When full, md_ready=0 and the producer must hold md_valid, md_rd and md_data stable.
  - A pushed entry with md_rd=0 is stored. When popped it drives rf_regWr=0, with no write and no busy clear.
- Scoreboard:
  - busy[r] is set at an edge when md_issue=1 and md_issue_rd=r!=0.
  - When a FIFO entry for r is popped, r is captured in the pending-clear register. busy[r] clears at the next edge, the same edge on which the register file commits.
  - Set and clear of the same r at the same edge: set wins.
  - Pipeline writes never change busy bits.
- stall = (readimport1!=0 and busy[readimport1]) or (readimport2!=0 and busy[readimport2]). It is combinational.
- The FIFO pointers wrap modulo MD_DEPTH.

Decomposition:
- Shared package regwb_pkg holds:
  - DATA_W and ADDR_W;
  - REG_ZERO = 5'd0;
  - the md_entry struct {rd[ADDR_W], data[DATA_W]}.
- One sub-module, regwb_fifo: a parameterised synchronous FIFO with push, pop, full, empty and count outputs.
- Arbitration, scoreboard and output registers live in the top level.

Test Plan:
- Pipeline only: wb_regWr=1, reg 8, data 0x12345678 at edge 1 -> rf_regWr=1, rf_writeimport=8, rf_Writedata=0x12345678 after edge 1; md_count stays 0.
- Mult/div while pipeline idle: md_issue with rd 9 -> stall=1 when readimport1=9 on the next cycle. Then md_valid with rd 9, data 0xCAFEF00D -> rf_* drive it one edge after acceptance; stall drops one edge after that.
- Contention: pipeline writes every cycle for 4 cycles while two md results arrive -> md_count reaches 2 and md_ready=0. The third md_valid is held off; the FIFO drains in order on the first idle cycles.
- Register 0: wb_regWr=1 with wb_writeimport=0, and md_issue with rd 0 -> rf_regWr=0, busy unchanged, stall=0 when readimport1=0.
- Same-edge reissue: a pop of rd 5 and a new md_issue rd 5 at the same edge -> busy[5] stays 1 and stall persists.
- Reset mid-stream: FIFO holding 2 entries and busy[3]=1, rst pulsed -> md_count=0, md_ready=1, stall=0, rf_regWr=0; no stale write appears afterwards.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regwb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // One buffered mult/div result: destination register plus value.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } md_entry;

  // Register 0 is hard-wired to zero, so it never takes a write or a busy bit.
  function automatic logic is_live_reg(input logic [ADDR_W-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Small synchronous FIFO for mult/div results. The head entry is visible
// combinationally so the arbiter can pop and register it in the same cycle.
module regwb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // Guard against overflow/underflow even if a caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Sole writer of the register file write port. The pipeline result always
// wins; buffered mult/div results fill idle cycles. A busy scoreboard tells
// decode which registers still wait on a mult/div result.
module regwb_arbiter #(
  parameter int MD_DEPTH = 2,
  parameter int DATA_W   = regwb_pkg::DATA_W,
  parameter int ADDR_W   = regwb_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_regWr,
  input  logic [ADDR_W-1:0]           wb_writeimport,
  input  logic [DATA_W-1:0]           wb_Writedata,
  input  logic                        md_issue,
  input  logic [ADDR_W-1:0]           md_issue_rd,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [ADDR_W-1:0]           md_rd,
  input  logic [DATA_W-1:0]           md_data,
  input  logic [ADDR_W-1:0]           readimport1,
  input  logic [ADDR_W-1:0]           readimport2,
  output logic                        stall,
  output logic                        rf_regWr,
  output logic [ADDR_W-1:0]           rf_writeimport,
  output logic [DATA_W-1:0]           rf_Writedata,
  output logic [$clog2(MD_DEPTH):0]   md_count
);

  import regwb_pkg::*;

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MD_DEPTH) + 1;

  logic              wb_live;
  logic              md_push;
  logic              md_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  md_entry           push_entry;
  md_entry           head_entry;

  logic              rf_regWr_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic              clr_valid_reg;
  logic [ADDR_W-1:0] clr_rd_reg;

  // A pipeline write to register 0 is treated exactly like an idle slot.
  assign wb_live = wb_regWr && is_live_reg(wb_writeimport);

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign md_ready = !fifo_full;
  assign md_push  = md_valid && md_ready;
  assign md_pop   = !wb_live && !fifo_empty;
  assign md_count = fifo_count;

  // Pack the offered result into a FIFO entry.
  always_comb begin
    push_entry      = '0;
    push_entry.rd   = md_rd;
    push_entry.data = md_data;
  end

  regwb_fifo #(
    .DEPTH (MD_DEPTH),
    .WIDTH ($bits(md_entry))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (md_push),
    .push_data (push_entry),
    .pop       (md_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write-port register: pipeline first, then FIFO head; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_regWr_reg <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
    end else if (wb_live) begin
      rf_regWr_reg <= 1'b1;
      rf_addr_reg  <= wb_writeimport;
      rf_data_reg  <= wb_Writedata;
    end else if (md_pop && is_live_reg(head_entry.rd)) begin
      rf_regWr_reg <= 1'b1;
      rf_addr_reg  <= head_entry.rd;
      rf_data_reg  <= head_entry.data;
    end else begin
      rf_regWr_reg <= 1'b0;
    end
  end

  assign rf_regWr       = rf_regWr_reg;
  assign rf_writeimport = rf_addr_reg;
  assign rf_Writedata   = rf_data_reg;

  // Per-register next busy state: a new issue beats the deferred clear.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_live
      assign busy_next[gi] =
          (md_issue && (md_issue_rd == ADDR_W'(gi))) ||
          (busy_reg[gi] && !(clr_valid_reg && (clr_rd_reg == ADDR_W'(gi))));
    end
  end

  // Scoreboard and deferred clear: the clear lands on the edge the register file commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      clr_valid_reg <= 1'b0;
      clr_rd_reg    <= '0;
    end else begin
      busy_reg      <= busy_next;
      clr_valid_reg <= md_pop && is_live_reg(head_entry.rd);
      clr_rd_reg    <= head_entry.rd;
    end
  end

  assign stall = (is_live_reg(readimport1) && busy_reg[readimport1]) ||
                 (is_live_reg(readimport2) && busy_reg[readimport2]);

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_regwb_arbiter;

  localparam int MD_DEPTH = 2;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      wb_regWr;
  logic [ADDR_W-1:0]         wb_writeimport;
  logic [DATA_W-1:0]         wb_Writedata;
  logic                      md_issue;
  logic [ADDR_W-1:0]         md_issue_rd;
  logic                      md_valid;
  logic                      md_ready;
  logic [ADDR_W-1:0]         md_rd;
  logic [DATA_W-1:0]         md_data;
  logic [ADDR_W-1:0]         readimport1;
  logic [ADDR_W-1:0]         readimport2;
  logic                      stall;
  logic                      rf_regWr;
  logic [ADDR_W-1:0]         rf_writeimport;
  logic [DATA_W-1:0]         rf_Writedata;
  logic [$clog2(MD_DEPTH):0] md_count;

  regwb_arbiter #(
    .MD_DEPTH (MD_DEPTH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_regWr       (wb_regWr),
    .wb_writeimport (wb_writeimport),
    .wb_Writedata   (wb_Writedata),
    .md_issue       (md_issue),
    .md_issue_rd    (md_issue_rd),
    .md_valid       (md_valid),
    .md_ready       (md_ready),
    .md_rd          (md_rd),
    .md_data        (md_data),
    .readimport1    (readimport1),
    .readimport2    (readimport2),
    .stall          (stall),
    .rf_regWr       (rf_regWr),
    .rf_writeimport (rf_writeimport),
    .rf_Writedata   (rf_Writedata),
    .md_count       (md_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          busy_m[32];
  bit          pend_v;
  logic [4:0]  pend_rd;
  logic        e_wr;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          live = 1'b0;
  bit          acc_last = 1'b1;

  // Model advances on each rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    ent_t ent;
    bit   popped;
    bit   room;
    popped = 1'b0;
    if (rst) begin
      q.delete();
      for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
      pend_v   = 1'b0;
      pend_rd  = '0;
      e_wr     = 1'b0;
      e_addr   = '0;
      e_data   = '0;
      acc_last = 1'b1;
      live     = 1'b1;
    end else if (live) begin
      room = (q.size() < MD_DEPTH);
      if (wb_regWr && wb_writeimport != 0) begin
        e_wr = 1'b1; e_addr = wb_writeimport; e_data = wb_Writedata;
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        popped = 1'b1;
        if (ent.rd != 0) begin
          e_wr = 1'b1; e_addr = ent.rd; e_data = ent.data;
        end else begin
          e_wr = 1'b0;
        end
      end else begin
        e_wr = 1'b0;
      end
      acc_last = md_valid && room;
      if (acc_last) q.push_back('{rd: md_rd, data: md_data});
      if (pend_v) busy_m[pend_rd] = 1'b0;
      if (md_issue && md_issue_rd != 0) busy_m[md_issue_rd] = 1'b1;
      pend_v  = popped && (ent.rd != 0);
      pend_rd = popped ? ent.rd : 5'd0;
    end
  end

  // Compare every output against the model once per cycle, mid-low-phase.
  always @(negedge clk) begin
    bit exp_stall;
    #2;
    if (live) begin
      exp_stall = (readimport1 != 0 && busy_m[readimport1]) ||
                  (readimport2 != 0 && busy_m[readimport2]);
      chk("model_rf_regWr", 64'(rf_regWr), 64'(e_wr));
      chk("model_rf_addr",  64'(rf_writeimport), 64'(e_addr));
      chk("model_rf_data",  64'(rf_Writedata), 64'(e_data));
      chk("model_md_count", 64'(md_count), 64'(q.size()));
      chk("model_md_ready", 64'(md_ready), 64'(q.size() < MD_DEPTH));
      chk("model_stall",    64'(stall), 64'(exp_stall));
    end
  end

  task automatic idle_inputs();
    wb_regWr = 0; wb_writeimport = 0; wb_Writedata = 0;
    md_issue = 0; md_issue_rd = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    readimport1 = 0; readimport2 = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_md_ready", 64'(md_ready), 64'd1);
    chk("reset_md_count", 64'(md_count), 64'd0);
    chk("reset_rf_regWr", 64'(rf_regWr), 64'd0);
    chk("reset_stall",    64'(stall), 64'd0);

    // Pipeline-only write
    @(negedge clk); wb_regWr = 1; wb_writeimport = 8; wb_Writedata = 32'h12345678;
    @(negedge clk); idle_inputs(); #3;
    chk("pipe_regWr", 64'(rf_regWr), 64'd1);
    chk("pipe_addr",  64'(rf_writeimport), 64'd8);
    chk("pipe_data",  64'(rf_Writedata), 64'h12345678);
    chk("pipe_count", 64'(md_count), 64'd0);

    // Mult/div result while pipeline idle
    @(negedge clk); md_issue = 1; md_issue_rd = 9;
    @(negedge clk); md_issue = 0; readimport1 = 9;
    md_valid = 1; md_rd = 9; md_data = 32'hCAFEF00D; #3;
    chk("md_stall_set", 64'(stall), 64'd1);
    @(negedge clk); md_valid = 0; #3;
    chk("md_count_one", 64'(md_count), 64'd1);
    chk("md_no_bypass", 64'(rf_regWr), 64'd0);
    @(negedge clk); #3;
    chk("md_regWr", 64'(rf_regWr), 64'd1);
    chk("md_addr",  64'(rf_writeimport), 64'd9);
    chk("md_data",  64'(rf_Writedata), 64'hCAFEF00D);
    chk("md_stall_hold", 64'(stall), 64'd1);
    @(negedge clk); #3;
    chk("md_stall_clear", 64'(stall), 64'd0);

    // Contention: pipeline busy four cycles, three results offered
    @(negedge clk); idle_inputs();
    wb_regWr = 1; wb_writeimport = 10; wb_Writedata = 32'hA0;
    md_valid = 1; md_rd = 1; md_data = 32'h111;
    @(negedge clk); wb_writeimport = 11; wb_Writedata = 32'hA1;
    md_rd = 2; md_data = 32'h222; #3;
    chk("cont_count1", 64'(md_count), 64'd1);
    @(negedge clk); wb_writeimport = 12; wb_Writedata = 32'hA2;
    md_rd = 3; md_data = 32'h333; #3;
    chk("cont_count2", 64'(md_count), 64'd2);
    chk("cont_full",   64'(md_ready), 64'd0);
    @(negedge clk); wb_writeimport = 13; wb_Writedata = 32'hA3; #3;
    chk("cont_full2", 64'(md_ready), 64'd0);
    chk("cont_pipe12", 64'(rf_writeimport), 64'd12);
    @(negedge clk); wb_regWr = 0; #3;
    chk("cont_pipe13", 64'(rf_writeimport), 64'd13);
    @(negedge clk); #3;
    chk("drain1_addr", 64'(rf_writeimport), 64'd1);
    chk("drain1_data", 64'(rf_Writedata), 64'h111);
    chk("drain1_count", 64'(md_count), 64'd1);
    @(negedge clk); md_valid = 0; #3;
    chk("drain2_addr", 64'(rf_writeimport), 64'd2);
    chk("drain2_data", 64'(rf_Writedata), 64'h222);
    @(negedge clk); #3;
    chk("drain3_addr", 64'(rf_writeimport), 64'd3);
    chk("drain3_data", 64'(rf_Writedata), 64'h333);
    chk("drain3_count", 64'(md_count), 64'd0);

    // Register 0 writes and issues are ignored
    @(negedge clk); idle_inputs();
    wb_regWr = 1; wb_writeimport = 0; wb_Writedata = 32'hDEAD;
    md_issue = 1; md_issue_rd = 0;
    @(negedge clk); idle_inputs(); #3;
    chk("r0_regWr", 64'(rf_regWr), 64'd0);
    chk("r0_hold_addr", 64'(rf_writeimport), 64'd3);
    chk("r0_stall", 64'(stall), 64'd0);

    // Reissue of rd 5 on the edge its deferred clear lands
    @(negedge clk); md_issue = 1; md_issue_rd = 5;
    @(negedge clk); md_issue = 0; md_valid = 1; md_rd = 5; md_data = 32'h55;
    readimport2 = 5;
    @(negedge clk); md_valid = 0;
    @(negedge clk); md_issue = 1; md_issue_rd = 5; #3;
    chk("reiss_addr", 64'(rf_writeimport), 64'd5);
    chk("reiss_stall1", 64'(stall), 64'd1);
    @(negedge clk); md_issue = 0; #3;
    chk("reiss_stall2", 64'(stall), 64'd1);

    // Reset with two buffered results and busy[3] outstanding
    @(negedge clk); idle_inputs();
    md_issue = 1; md_issue_rd = 3; readimport1 = 3;
    wb_regWr = 1; wb_writeimport = 20; wb_Writedata = 32'h20;
    md_valid = 1; md_rd = 3; md_data = 32'hA;
    @(negedge clk); md_issue = 0; wb_writeimport = 21; md_rd = 4; md_data = 32'hB;
    @(negedge clk); rst = 1; wb_regWr = 0; md_valid = 0; #3;
    chk("prerst_count", 64'(md_count), 64'd2);
    chk("prerst_stall", 64'(stall), 64'd1);
    @(negedge clk); rst = 0; #3;
    chk("rst_count", 64'(md_count), 64'd0);
    chk("rst_ready", 64'(md_ready), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_regWr", 64'(rf_regWr), 64'd0);
    repeat (2) begin
      @(negedge clk); #3;
      chk("rst_no_stale", 64'(rf_regWr), 64'd0);
    end

    // Randomized traffic; producer holds an unaccepted offer
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 299) == 0);
      wb_regWr       = ($urandom_range(0, 99) < 45);
      wb_writeimport = 5'($urandom_range(0, 7));
      wb_Writedata   = $urandom;
      md_issue       = ($urandom_range(0, 3) == 0);
      md_issue_rd    = 5'($urandom_range(0, 7));
      if (!(md_valid && !acc_last)) begin
        md_valid = 1'($urandom_range(0, 1));
        md_rd    = 5'($urandom_range(0, 7));
        md_data  = $urandom;
      end
      readimport1 = 5'($urandom_range(0, 7));
      readimport2 = 5'($urandom_range(0, 7));
    end

    @(negedge clk); idle_inputs(); rst = 0;
    repeat (4) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
